// File: rtl/field_pack_arbiter.sv
// rtl/field_pack_arbiter.sv - round-robin requester arbiter with burst lock feeding one registered packed-word output
module field_pack_arbiter #(
    parameter int                N_REQ     = 4,
    parameter int                DATA_W    = 16,
    parameter int                HDR_W     = 12,
    parameter logic [HDR_W-1:0]  HDR_VAL   = 12'h345,
    parameter int                MAX_BURST = 1,
    localparam int               ID_W      = $clog2(N_REQ),
    localparam int               OUT_W     = HDR_W + ID_W + DATA_W
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic                    o_out_valid,
    output logic [OUT_W-1:0]        o_out_data,
    input  logic                    i_out_ready
);
    localparam int               CNT_W       = $clog2(MAX_BURST + 1);
    localparam logic [ID_W:0]    N_REQ_L     = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] MAX_BURST_L = CNT_W'(MAX_BURST);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] burst_q, burst_d;

    logic [ID_W-1:0]  grant;
    logic [ID_W:0]    idx;
    logic             found;
    logic             slot_free;
    logic             accept;
    logic [CNT_W-1:0] n;

    // ptr + i stays below 2*N_REQ, so one conditional subtract is a full mod N_REQ
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (idx >= N_REQ_L) begin
                idx = idx - N_REQ_L;
            end
            if (!found && i_req_valid[idx[ID_W-1:0]]) begin
                found = 1'b1;
                grant = idx[ID_W-1:0];
            end
        end
    end

    assign slot_free   = (state_q == S_EMPTY) || i_out_ready;
    assign accept      = !i_arst && slot_free && found;
    assign o_req_ready = accept ? (N_REQ'(1) << grant) : '0;
    assign o_out_valid = (state_q == S_FULL);
    assign o_out_data  = data_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        n       = (grant == ptr_q && burst_q != '0) ? burst_q + 1'b1 : CNT_W'(1);
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (i_out_ready && !accept) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (accept) begin
            data_d = {HDR_VAL, grant, i_req_data[grant*DATA_W +: DATA_W]};
            // A finished burst hands the search start to the next requester
            if (n == MAX_BURST_L) begin
                ptr_d   = (grant == LAST_ID) ? '0 : grant + 1'b1;
                burst_d = '0;
            end else begin
                ptr_d   = grant;
                burst_d = n;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
        end
    end
endmodule

// File: tb/tb_field_pack_arbiter.sv
// tb/tb_field_pack_arbiter.sv - directed bench for field_pack_arbiter (round robin, burst of 2, three requesters)
module tb_field_pack_arbiter;
    logic        clk = 1'b0;
    logic        arst;

    logic [3:0]  v_a, rdy_a;
    logic [63:0] d_a;
    logic        ordy_a, ov_a;
    logic [29:0] od_a;

    logic [3:0]  v_b, rdy_b;
    logic [63:0] d_b;
    logic        ordy_b, ov_b;
    logic [29:0] od_b;

    logic [2:0]  v_c, rdy_c;
    logic [47:0] d_c;
    logic        ordy_c, ov_c;
    logic [29:0] od_c;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] bv [14];
    int         bg [14];

    always #5 clk = ~clk;

    field_pack_arbiter #(.N_REQ(4), .MAX_BURST(1)) u_rr (
        .i_clk(clk), .i_arst(arst), .i_req_valid(v_a), .i_req_data(d_a),
        .o_req_ready(rdy_a), .o_out_valid(ov_a), .o_out_data(od_a), .i_out_ready(ordy_a)
    );

    field_pack_arbiter #(.N_REQ(4), .MAX_BURST(2)) u_bu (
        .i_clk(clk), .i_arst(arst), .i_req_valid(v_b), .i_req_data(d_b),
        .o_req_ready(rdy_b), .o_out_valid(ov_b), .o_out_data(od_b), .i_out_ready(ordy_b)
    );

    field_pack_arbiter #(.N_REQ(3), .MAX_BURST(1)) u_od (
        .i_clk(clk), .i_arst(arst), .i_req_valid(v_c), .i_req_data(d_c),
        .o_req_ready(rdy_c), .o_out_valid(ov_c), .o_out_data(od_c), .i_out_ready(ordy_c)
    );

    function automatic logic [29:0] wrd(input int g);
        logic [1:0] id;
        id = 2'(g);
        return {12'h345, id, 16'hA000 + 16'(g)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bv = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1101, 4'hF, 4'hF};
        bg = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 2, 2, 3};
        arst = 1'b1;
        v_a = '0; v_b = '0; v_c = '0;
        d_a = '0;
        d_b = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        d_c = {16'hA002, 16'hA001, 16'hA000};
        ordy_a = 1'b1; ordy_b = 1'b1; ordy_c = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 64'(ov_a), 64'd0);
        check("rst_data", 64'(od_a), 64'd0);
        check("rst_ready", 64'(rdy_a), 64'd0);
        v_a = 4'hF;
        #1;
        check("rst_ready_masked", 64'(rdy_a), 64'd0);
        v_a = '0;
        @(negedge clk);
        arst = 1'b0;

        // single word from requester 2
        v_a = 4'b0100;
        d_a[47:32] = 16'h3456;
        #1;
        check("single_ready", 64'(rdy_a), 64'h4);
        @(negedge clk);
        v_a = '0;
        #1;
        check("single_data", 64'(od_a), 64'h0D163456);
        check("single_valid", 64'(ov_a), 64'd1);
        check("single_no_ready", 64'(rdy_a), 64'd0);
        @(negedge clk);
        #1;
        check("drain_valid", 64'(ov_a), 64'd0);
        check("drain_data_hold", 64'(od_a), 64'h0D163456);

        // mid-stream reset: search starts at 3 after the single word
        d_a = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        v_a = 4'hF;
        @(negedge clk);
        #1;
        check("pre_rst_word", 64'(od_a), 64'(wrd(3)));
        check("pre_rst_valid", 64'(ov_a), 64'd1);
        #1;
        arst = 1'b1;
        #1;
        check("midrst_valid", 64'(ov_a), 64'd0);
        check("midrst_data", 64'(od_a), 64'd0);
        check("midrst_ready", 64'(rdy_a), 64'd0);
        @(negedge clk);
        arst = 1'b0;

        // round robin, all valid
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i > 0) check("rr_data", 64'(od_a), 64'(wrd((i - 1) % 4)));
            check("rr_ready", 64'(rdy_a), 64'(4'b0001 << (i % 4)));
            @(negedge clk);
        end

        // backpressure holds the grant-1 word
        ordy_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready", 64'(rdy_a), 64'd0);
            check("bp_data", 64'(od_a), 64'(wrd(1)));
            check("bp_valid", 64'(ov_a), 64'd1);
            @(negedge clk);
        end
        ordy_a = 1'b1;
        #1;
        check("bp_release_ready", 64'(rdy_a), 64'h4);
        @(negedge clk);
        v_a = '0;
        #1;
        check("bp_next_data", 64'(od_a), 64'(wrd(2)));
        check("bp_next_valid", 64'(ov_a), 64'd1);
        @(negedge clk);
        #1;
        check("bp_drain", 64'(ov_a), 64'd0);

        // burst of 2, with requester 1 dropping after its first grant
        for (int i = 0; i < 14; i++) begin
            v_b = bv[i];
            #1;
            if (i > 0) check("burst_data", 64'(od_b), 64'(wrd(bg[i - 1])));
            check("burst_ready", 64'(rdy_b), 64'(4'b0001 << bg[i]));
            @(negedge clk);
        end
        v_b = '0;
        #1;
        check("burst_last_data", 64'(od_b), 64'(wrd(3)));

        // three requesters wrap 2 -> 0
        for (int i = 0; i < 6; i++) begin
            v_c = 3'b111;
            #1;
            if (i > 0) check("odd_data", 64'(od_c), 64'(wrd((i - 1) % 3)));
            check("odd_ready", 64'(rdy_c), 64'(3'b001 << (i % 3)));
            @(negedge clk);
        end
        v_c = '0;
        #1;
        check("odd_last_data", 64'(od_c), 64'(wrd(2)));
        check("odd_last_valid", 64'(ov_c), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
